// File: rtl/wb_reset_sequencer.sv
// Reset sequencer: key debounce, PLL lock qualification and software reset merged into a
// glitch-free, minimum-width active-high Wishbone reset, with last-cause and event counter.
module wb_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_WIDTH       = 18
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_i,
  input  logic       key_n_i,
  input  logic       pll_locked_i,
  input  logic       sw_req_i,
  output logic       wb_rst_o,
  output logic [1:0] state_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_count_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_KEY = 2'd1;
  localparam logic [1:0] CAUSE_PLL = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STRETCH   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_key_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_key_s;
  logic                   w_lock_s;

  logic                   r_key_db;
  logic [CNT_WIDTH-1:0]   r_db_cnt;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [HOLD_W-1:0]      r_hold;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic [1:0]             r_cause;
  logic [1:0]             w_cause_nxt;
  logic                   w_enter_assert;
  logic [7:0]             r_count;
  logic                   r_wb_rst;

  // Key chain resets to "released", lock chain to "unlocked".
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_key_sync  <= '1;
      r_lock_sync <= '0;
    end else begin
      r_key_sync  <= {r_key_sync[SYNC_STAGES-2:0], key_n_i};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign w_key_s  = r_key_sync[SYNC_STAGES-1];
  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

  // A new key level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_key_db <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_key_s == r_key_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_key_db <= w_key_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_ASSERT;
      r_hold   <= '0;
      r_cause  <= CAUSE_POR;
      r_count  <= '0;
      r_wb_rst <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_cause  <= w_cause_nxt;
      r_wb_rst <= (w_state_nxt != ST_RUN);
      if (w_enter_assert && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = '0;
    w_cause_nxt    = r_cause;
    w_enter_assert = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        if (r_key_db) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = ST_STRETCH;
      end
      ST_STRETCH: begin
        // A source dropping again beats completing the stretch.
        if (!w_lock_s || !r_key_db) begin
          w_state_nxt    = ST_ASSERT;
          w_enter_assert = 1'b1;
          w_cause_nxt    = !w_lock_s ? CAUSE_PLL : CAUSE_KEY;
        end else if (r_hold == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt    = ST_ASSERT;
          w_enter_assert = 1'b1;
          w_cause_nxt    = CAUSE_PLL;
        end else if (!r_key_db) begin
          w_state_nxt    = ST_ASSERT;
          w_enter_assert = 1'b1;
          w_cause_nxt    = CAUSE_KEY;
        end else if (sw_req_i) begin
          w_state_nxt    = ST_ASSERT;
          w_enter_assert = 1'b1;
          w_cause_nxt    = CAUSE_SW;
        end
      end
      default: w_state_nxt = ST_ASSERT;
    endcase
  end

  assign wb_rst_o    = r_wb_rst;
  assign state_o     = r_state;
  assign cause_o     = r_cause;
  assign rst_count_o = r_count;

endmodule

// File: tb/tb_wb_reset_sequencer.sv
// Bench for wb_reset_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a sample-history / countdown reference model.
module tb_wb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       lock  = 1'b1;
  logic       sw    = 1'b0;
  logic       wb_rst;
  logic [1:0] state;
  logic [1:0] cause;
  logic [7:0] cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  wb_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .CNT_WIDTH      (3)
  ) dut (
    .wb_clk_i    (clk),
    .rst_n_i     (rst_n),
    .key_n_i     (key_n),
    .pll_locked_i(lock),
    .sw_req_i    (sw),
    .wb_rst_o    (wb_rst),
    .state_o     (state),
    .cause_o     (cause),
    .rst_count_o (cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: sample histories, a run length of disagreeing samples, a hold countdown
  int m_key_q[$];
  int m_lock_q[$];
  int m_db, m_diff, m_phase, m_hold_left, m_cause, m_cnt, m_rst;

  task automatic model_reset();
    m_key_q  = {};
    m_lock_q = {};
    for (int i = 0; i < SYNC; i++) begin
      m_key_q.push_back(1);
      m_lock_q.push_back(0);
    end
    m_db = 1; m_diff = 0; m_phase = 0; m_hold_left = 0;
    m_cause = 0; m_cnt = 0; m_rst = 1;
  endtask

  task automatic model_step();
    int ks, ls, db_old, ev;
    ks     = m_key_q[SYNC-1];
    ls     = m_lock_q[SYNC-1];
    db_old = m_db;
    m_key_q.push_front(int'(key_n));
    void'(m_key_q.pop_back());
    m_lock_q.push_front(int'(lock));
    void'(m_lock_q.pop_back());
    if (ks != m_db) begin
      m_diff++;
      if (m_diff == DEB) begin
        m_db   = ks;
        m_diff = 0;
      end
    end else begin
      m_diff = 0;
    end
    ev = 0;
    case (m_phase)
      0: if (db_old != 0) m_phase = 1;
      1: if (ls != 0) begin m_phase = 2; m_hold_left = HOLD; end
      2: begin
        if (ls == 0) ev = 2;
        else if (db_old == 0) ev = 1;
        else begin
          m_hold_left--;
          if (m_hold_left == 0) m_phase = 3;
        end
      end
      3: begin
        if (ls == 0) ev = 2;
        else if (db_old == 0) ev = 1;
        else if (sw) ev = 3;
      end
      default: ;
    endcase
    if (ev != 0) begin
      m_phase = 0;
      m_cause = ev;
      if (m_cnt < 255) m_cnt++;
    end
    m_rst = (m_phase != 3) ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_wb_rst", int'(wb_rst), m_rst);
      chk("cyc_state", int'(state), m_phase);
      chk("cyc_cause", int'(cause), m_cause);
      chk("cyc_count", int'(cnt), m_cnt);
    end
  end

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sw();
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
  endtask

  task automatic wait_run(input int limit);
    int k;
    k = 0;
    while (wb_rst !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (wb_rst !== 1'b0) chk("wait_run_timeout", 1, 0);
  endtask

  initial begin
    int key_run, lock_run;
    rst_n = 1'b0; key_n = 1'b1; lock = 1'b1; sw = 1'b0;
    edges(3);
    cmp_en = 1'b1;
    chk("reset_wb_rst", int'(wb_rst), 1);
    chk("reset_state", int'(state), 0);
    chk("reset_cause", int'(cause), 0);
    chk("reset_count", int'(cnt), 0);

    // power-on release
    rst_n = 1'b1;
    edges(6);
    chk("por_edge6_rst", int'(wb_rst), 1);
    edges(1);
    chk("por_edge7_rst", int'(wb_rst), 0);
    chk("por_state", int'(state), 3);
    chk("por_cause", int'(cause), 0);
    chk("por_count", int'(cnt), 0);

    // bounce shorter than the debounce window
    for (int r = 0; r < 10; r++) begin
      key_n = 1'b0; edges(7);
      key_n = 1'b1; edges(1);
    end
    edges(4);
    chk("bounce_rst", int'(wb_rst), 0);
    chk("bounce_count", int'(cnt), 0);

    // real key press
    key_n = 1'b0;
    edges(10);
    chk("key_edge10_rst", int'(wb_rst), 0);
    edges(1);
    chk("key_edge11_rst", int'(wb_rst), 1);
    chk("key_cause", int'(cause), 1);
    chk("key_count", int'(cnt), 1);
    edges(20);
    chk("key_held_state", int'(state), 0);
    key_n = 1'b1;
    edges(15);
    chk("key_rel_edge15_rst", int'(wb_rst), 1);
    edges(1);
    chk("key_rel_edge16_rst", int'(wb_rst), 0);

    // PLL loss
    edges(3);
    lock = 1'b0;
    edges(2);
    chk("pll_edge2_rst", int'(wb_rst), 0);
    edges(1);
    chk("pll_edge3_rst", int'(wb_rst), 1);
    chk("pll_cause", int'(cause), 2);
    chk("pll_count", int'(cnt), 2);
    edges(10);
    chk("pll_wait_state", int'(state), 1);
    lock = 1'b1;
    edges(6);
    chk("pll_back_edge6_rst", int'(wb_rst), 1);
    edges(1);
    chk("pll_back_edge7_rst", int'(wb_rst), 0);

    // software request, and an ignored request during STRETCH
    edges(3);
    pulse_sw();
    chk("sw_edge1_rst", int'(wb_rst), 1);
    chk("sw_cause", int'(cause), 3);
    chk("sw_count", int'(cnt), 3);
    edges(2);
    chk("sw_stretch_state", int'(state), 2);
    pulse_sw();
    edges(2);
    chk("sw_edge6_rst", int'(wb_rst), 1);
    edges(1);
    chk("sw_edge7_rst", int'(wb_rst), 0);
    chk("sw_ignored_count", int'(cnt), 3);

    // key_db fall coincident with sw_req
    edges(3);
    key_n = 1'b0;
    edges(10);
    pulse_sw();
    chk("simul_rst", int'(wb_rst), 1);
    chk("simul_cause", int'(cause), 1);
    chk("simul_count", int'(cnt), 4);
    key_n = 1'b1;
    wait_run(60);

    // lock loss while stretching
    edges(3);
    pulse_sw();
    edges(2);
    chk("stretch_state", int'(state), 2);
    lock = 1'b0;
    edges(3);
    chk("stretch_loss_state", int'(state), 0);
    chk("stretch_loss_cause", int'(cause), 2);
    chk("stretch_loss_count", int'(cnt), 6);
    lock = 1'b1;
    wait_run(60);

    // randomized mix of bouncing key, lock drops and sw pulses
    key_run  = 0;
    lock_run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (key_run == 0) begin
        key_n   = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
        key_run = $urandom_range(1, 20);
      end
      key_run--;
      if (lock_run == 0) begin
        if ($urandom_range(0, 99) < 3) begin
          lock     = 1'b0;
          lock_run = $urandom_range(1, 6);
        end else begin
          lock = 1'b1;
        end
      end else begin
        lock_run--;
      end
      sw = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      edges(1);
    end
    key_n = 1'b1; lock = 1'b1; sw = 1'b0;
    wait_run(100);

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      pulse_sw();
      wait_run(30);
    end
    chk("sat_count", int'(cnt), 255);

    // asynchronous reset in the middle of STRETCH
    edges(2);
    pulse_sw();
    edges(2);
    chk("ar_pre_state", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wb_rst", int'(wb_rst), 1);
    chk("ar_state", int'(state), 0);
    chk("ar_cause", int'(cause), 0);
    chk("ar_count", int'(cnt), 0);
    edges(3);
    rst_n = 1'b1;
    wait_run(30);
    chk("ar_after_cause", int'(cause), 0);
    chk("ar_after_count", int'(cnt), 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
